// File: rtl/ex_mem_stage_pkg.sv
// rtl/ex_mem_stage_pkg.sv - shared state encodings and width helpers for the EX/MEM stage
package ex_mem_stage_pkg;

  // Bit 0 = main entry valid, bit 1 = skid entry valid, so both valids
  // (and therefore IN_READY) come straight off state flops.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  localparam int DEF_DATA_W    = 32;
  localparam int EDIT_SERIAL_W = 2 * DEF_DATA_W + 1;

  // Memory packet width {MemWrite, ALUOut, rt} for an arbitrary data width.
  function automatic int editSerialWidth(input int dataW);
    return 2 * dataW + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry skid buffer with registered ready and flush
module pipe_skid_buf
  import ex_mem_stage_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [PAYLOAD_W-1:0] IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [PAYLOAD_W-1:0] OUT_DATA
);

  logic [1:0]           state;
  logic [1:0]           nextState;
  logic [PAYLOAD_W-1:0] mainData;
  logic [PAYLOAD_W-1:0] skidData;
  logic                 accept;
  logic                 transfer;
  logic                 loadMainFromIn;
  logic                 loadMainFromSkid;
  logic                 loadSkid;

  // Ready only depends on the skid flop, never on OUT_READY.
  assign IN_READY  = !state[1];
  assign OUT_VALID = state[0];
  assign OUT_DATA  = mainData;

  assign accept   = IN_VALID && IN_READY && !FLUSH;
  assign transfer = OUT_VALID && OUT_READY;

  // Next-state and load selection; flush wins over everything.
  always_comb begin
    nextState        = state;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    if (FLUSH) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState      = ONE;
            loadMainFromIn = 1'b1;
          end
        end
        ONE: begin
          if (transfer && accept) begin
            loadMainFromIn = 1'b1;
          end else if (transfer) begin
            nextState = EMPTY;
          end else if (accept) begin
            nextState = FULL;
            loadSkid  = 1'b1;
          end
        end
        FULL: begin
          if (transfer) begin
            nextState        = ONE;
            loadMainFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Payload registers; main keeps its contents when it goes invalid so the
  // stage outputs hold their last value.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      mainData <= '0;
      skidData <= '0;
    end else begin
      if (loadMainFromIn) begin
        mainData <= IN_DATA;
      end else if (loadMainFromSkid) begin
        mainData <= skidData;
      end
      if (loadSkid) begin
        skidData <= IN_DATA;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with skid buffering and stall counter
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                               CLOCK,
  input  logic                               RESET_N,
  input  logic                               IN_VALID,
  output logic                               IN_READY,
  input  logic                               FLUSH,
  input  logic [DATA_W-1:0]                  ALUOutE,
  input  logic [DATA_W-1:0]                  rtE,
  input  logic [RADDR_W-1:0]                 wb_addrE,
  input  logic [RADDR_W-1:0]                 rs_addrE,
  input  logic [RADDR_W-1:0]                 rt_addrE,
  input  logic                               RegWriteE,
  input  logic                               MemtoRegE,
  input  logic                               MemWriteE,
  input  logic                               OUT_READY,
  output logic                               OUT_VALID,
  output logic [editSerialWidth(DATA_W)-1:0] EDIT_SERIAL,
  output logic [DATA_W-1:0]                  ALUOutM,
  output logic [RADDR_W-1:0]                 wb_addrM,
  output logic [RADDR_W-1:0]                 rs_addrM,
  output logic [RADDR_W-1:0]                 rt_addrM,
  output logic                               RegWriteM,
  output logic                               MemtoRegM,
  output logic [15:0]                        STALL_CNT
);

  localparam int PAYLOAD_W = 2 * DATA_W + 3 * RADDR_W + 3;

  logic [PAYLOAD_W-1:0] inData;
  logic [PAYLOAD_W-1:0] headData;
  logic                 headValid;
  logic                 headMemWrite;
  logic                 headRegWrite;
  logic [DATA_W-1:0]    headRt;

  assign inData = {MemWriteE, ALUOutE, rtE, wb_addrE, rs_addrE, rt_addrE,
                   RegWriteE, MemtoRegE};

  pipe_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_buf (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (inData),
    .OUT_VALID (headValid),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (headData)
  );

  assign {headMemWrite, ALUOutM, headRt, wb_addrM, rs_addrM, rt_addrM,
          headRegWrite, MemtoRegM} = headData;

  // Side-effecting control bits are masked when no entry is presented.
  assign OUT_VALID   = headValid;
  assign RegWriteM   = headRegWrite && headValid;
  assign EDIT_SERIAL = {headMemWrite && headValid, ALUOutM, headRt};

  // Saturating back-pressure counter; survives flush, cleared only by reset.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      STALL_CNT <= 16'd0;
    end else if (headValid && !OUT_READY && (STALL_CNT != 16'hFFFF)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage with queue model
module tb_ex_mem_stage;

  typedef struct packed {
    logic        memWrite;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wb;
    logic [4:0]  rs;
    logic [4:0]  rtA;
    logic        regWrite;
    logic        memToReg;
  } ent_t;

  logic        CLOCK;
  logic        RESET_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic        FLUSH;
  logic [31:0] ALUOutE;
  logic [31:0] rtE;
  logic [4:0]  wb_addrE;
  logic [4:0]  rs_addrE;
  logic [4:0]  rt_addrE;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        OUT_READY;
  logic        OUT_VALID;
  logic [64:0] EDIT_SERIAL;
  logic [31:0] ALUOutM;
  logic [4:0]  wb_addrM;
  logic [4:0]  rs_addrM;
  logic [4:0]  rt_addrM;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [15:0] STALL_CNT;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  ent_t        q[$];
  ent_t        shown;
  int unsigned stallModel;

  ex_mem_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .FLUSH       (FLUSH),
    .ALUOutE     (ALUOutE),
    .rtE         (rtE),
    .wb_addrE    (wb_addrE),
    .rs_addrE    (rs_addrE),
    .rt_addrE    (rt_addrE),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .OUT_READY   (OUT_READY),
    .OUT_VALID   (OUT_VALID),
    .EDIT_SERIAL (EDIT_SERIAL),
    .ALUOutM     (ALUOutM),
    .wb_addrM    (wb_addrM),
    .rs_addrM    (rs_addrM),
    .rt_addrM    (rt_addrM),
    .RegWriteM   (RegWriteM),
    .MemtoRegM   (MemtoRegM),
    .STALL_CNT   (STALL_CNT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: an ordered queue of at most two entries.
  initial begin
    ent_t inEnt;
    bit   acc;
    bit   xfer;
    q.delete();
    shown      = '0;
    stallModel = 0;
    forever begin
      @(posedge CLOCK or negedge RESET_N);
      if (!RESET_N) begin
        q.delete();
        shown      = '0;
        stallModel = 0;
      end else begin
        inEnt = '{MemWriteE, ALUOutE, rtE, wb_addrE, rs_addrE, rt_addrE, RegWriteE, MemtoRegE};
        acc   = IN_VALID && (q.size() < 2) && !FLUSH;
        xfer  = (q.size() > 0) && OUT_READY;
        if ((q.size() > 0) && !OUT_READY && (stallModel < 65535)) stallModel++;
        if (xfer) void'(q.pop_front());
        if (FLUSH) q.delete();
        else if (acc) q.push_back(inEnt);
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    bit expValid;
    forever begin
      @(negedge CLOCK);
      if (checkEn) begin
        expValid = (q.size() > 0);
        chk("m_in_ready", IN_READY, q.size() < 2);
        chk("m_out_valid", OUT_VALID, expValid);
        chk("m_edit_serial", EDIT_SERIAL, {shown.memWrite & expValid, shown.alu, shown.rt});
        chk("m_aluout", ALUOutM, shown.alu);
        chk("m_fields", {wb_addrM, rs_addrM, rt_addrM, RegWriteM, MemtoRegM},
            {shown.wb, shown.rs, shown.rtA, shown.regWrite & expValid, shown.memToReg});
        chk("m_stall_cnt", STALL_CNT, stallModel[15:0]);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLOCK);
    @(negedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [4:0] wb, input logic rw, input logic mw);
    IN_VALID  = v;
    ALUOutE   = alu;
    rtE       = rt;
    wb_addrE  = wb;
    rs_addrE  = wb + 5'd1;
    rt_addrE  = wb + 5'd2;
    RegWriteE = rw;
    MemtoRegE = alu[0];
    MemWriteE = mw;
  endtask

  initial begin
    RESET_N   = 1'b0;
    FLUSH     = 1'b0;
    OUT_READY = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    chk("rst_in_ready", IN_READY, 1'b1);
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_edit_serial", EDIT_SERIAL, 65'h0);
    chk("rst_stall", STALL_CNT, 16'h0);
    RESET_N = 1'b1;
    checkEn = 1'b1;

    // Streaming, one entry per cycle.
    OUT_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 32'h1000 + i, 5'(i), 1'b1, 1'b0);
      step();
      chk("stream_alu", ALUOutM, i);
      chk("stream_valid", OUT_VALID, 1'b1);
      chk("stream_ready", IN_READY, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    chk("stream_drain", OUT_VALID, 1'b0);

    // Back-pressure.
    OUT_READY = 1'b0;
    drive(1'b1, 32'hA, 32'hA0, 5'd10, 1'b1, 1'b0);
    step();
    chk("bp_a_main", ALUOutM, 32'hA);
    chk("bp_ready1", IN_READY, 1'b1);
    drive(1'b1, 32'hB, 32'hB0, 5'd11, 1'b1, 1'b0);
    step();
    chk("bp_full_ready", IN_READY, 1'b0);
    chk("bp_stall1", STALL_CNT, 16'd1);
    drive(1'b1, 32'hC, 32'hC0, 5'd12, 1'b0, 1'b1);
    step();
    chk("bp_stall2", STALL_CNT, 16'd2);
    chk("bp_hold_a", ALUOutM, 32'hA);
    OUT_READY = 1'b1;
    step();
    chk("bp_b_main", ALUOutM, 32'hB);
    chk("bp_ready2", IN_READY, 1'b1);
    step();
    chk("bp_c_main", ALUOutM, 32'hC);
    chk("bp_c_valid", OUT_VALID, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    chk("bp_empty", OUT_VALID, 1'b0);
    chk("bp_stall_keep", STALL_CNT, 16'd2);

    // Flush while full with a simultaneous offer.
    OUT_READY = 1'b0;
    drive(1'b1, 32'hD, 32'hD0, 5'd13, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'hE, 32'hE0, 5'd14, 1'b1, 1'b1);
    step();
    chk("fl_full", IN_READY, 1'b0);
    FLUSH = 1'b1;
    drive(1'b1, 32'hF, 32'hF0, 5'd15, 1'b1, 1'b1);
    step();
    chk("fl_valid", OUT_VALID, 1'b0);
    chk("fl_regwrite", RegWriteM, 1'b0);
    chk("fl_msb", EDIT_SERIAL[64], 1'b0);
    chk("fl_ready", IN_READY, 1'b1);
    chk("fl_hold_alu", ALUOutM, 32'hD);
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    chk("fl_no_trace", OUT_VALID, 1'b0);
    chk("fl_stall", STALL_CNT, 16'd4);

    // Store packet.
    OUT_READY = 1'b1;
    drive(1'b1, 32'h100, 32'hDEAD, 5'd3, 1'b0, 1'b1);
    step();
    chk("st_packet", EDIT_SERIAL, {1'b1, 32'h100, 32'hDEAD});
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    chk("st_gated", EDIT_SERIAL, {1'b0, 32'h100, 32'hDEAD});

    // Saturation.
    OUT_READY = 1'b0;
    drive(1'b1, 32'h77, 32'h7, 5'd7, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (65540) step();
    chk("sat_stall", STALL_CNT, 16'hFFFF);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("sat_no_clear", STALL_CNT, 16'hFFFF);

    // Reset mid-transfer.
    OUT_READY = 1'b1;
    drive(1'b1, 32'h55, 32'h5555, 5'd9, 1'b1, 1'b1);
    step();
    chk("rm_pre_valid", OUT_VALID, 1'b1);
    RESET_N = 1'b0;
    #1;
    chk("rm_valid", OUT_VALID, 1'b0);
    chk("rm_ready", IN_READY, 1'b1);
    chk("rm_serial", EDIT_SERIAL, 65'h0);
    chk("rm_fields", {ALUOutM, wb_addrM, rs_addrM, rt_addrM, RegWriteM, MemtoRegM}, 50'h0);
    chk("rm_stall", STALL_CNT, 16'h0);
    #1;
    RESET_N = 1'b1;
    drive(1'b1, 32'h66, 32'h6666, 5'd6, 1'b1, 1'b0);
    step();
    chk("rm_first_accept", ALUOutM, 32'h66);
    chk("rm_first_valid", OUT_VALID, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    checkEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
